// File: rtl/input_debounce.sv
// input_debounce: synchronise, debounce and edge-detect WIDTH raw board inputs
//   clk, rst            clock, asynchronous active-high reset
//   sw_in               raw asynchronous inputs
//   sw_level            debounced levels
//   sw_rise, sw_fall    one-clk pulses on debounced 0->1 / 1->0
//   evt_valid/mask/level/ovf, evt_ready
//                       change-event register with valid/ready accept,
//                       built only when DEBOUNCE_EVENT_EN is defined (else driven 0)
module input_debounce #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV = 50000,
  parameter int DB_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic evt_valid,
  output logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] evt_level,
  output logic evt_ovf,
  input  logic evt_ready
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_TICKS - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] s;
  logic tick;
  assign s = sync[SYNC_STAGES-1];
  assign tick = pcnt == PMAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_LEVEL}};
      pcnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw_in};
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  // A bit's counter only advances on ticks while it disagrees with the accepted
  // level; any agreement restarts qualification from zero.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_level <= RESET_LEVEL;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sw_rise[i] <= 1'b0;
        sw_fall[i] <= 1'b0;
        if (s[i] == sw_level[i]) cnt[i] <= '0;
        else if (tick && cnt[i] == CMAX) begin
          cnt[i] <= '0;
          sw_level[i] <= s[i];
          sw_rise[i] <= s[i];
          sw_fall[i] <= !s[i];
        end else if (tick) cnt[i] <= cnt[i] + 1'b1;
      end
    end
`ifdef DEBOUNCE_EVENT_EN
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic [WIDTH-1:0] chg;
  assign chg = sw_rise | sw_fall;
  assign evt_valid = state == PEND;
  // Pulses and sw_level update together, so sw_level already holds the new value
  // in the clk where chg is seen.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      evt_mask <= '0;
      evt_level <= '0;
      evt_ovf <= 1'b0;
    end else if (state == IDLE) begin
      if (|chg) begin
        state <= PEND;
        evt_mask <= chg;
        evt_level <= sw_level;
        evt_ovf <= 1'b0;
      end
    end else if (evt_ready) begin
      evt_mask <= chg;
      evt_ovf <= 1'b0;
      if (|chg) evt_level <= sw_level;
      else state <= IDLE;
    end else if (|chg) begin
      evt_mask <= evt_mask | chg;
      evt_level <= sw_level;
      evt_ovf <= evt_ovf | |(evt_mask & chg);
    end
`else
  logic unused_ready;
  assign unused_ready = evt_ready;
  assign evt_valid = 1'b0;
  assign evt_mask = '0;
  assign evt_level = '0;
  assign evt_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed self-checking bench for input_debounce (TICK_DIV=4, DB_TICKS=3)
module tb_input_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt_ready = 1'b0;
  logic [7:0] sw_in = 8'hFF;
  logic [7:0] sw_level, sw_rise, sw_fall, evt_mask, evt_level;
  logic evt_valid, evt_ovf;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int n;
  logic [7:0] rise_or = '0;
  logic [7:0] fall_or = '0;
  typedef struct {
    logic [7:0] sw;
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;
  vec_t vecs [5];
  input_debounce #(
    .WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(4), .DB_TICKS(3), .RESET_LEVEL(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .sw_level(sw_level), .sw_rise(sw_rise),
    .sw_fall(sw_fall), .evt_valid(evt_valid), .evt_mask(evt_mask),
    .evt_level(evt_level), .evt_ovf(evt_ovf), .evt_ready(evt_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    rise_or |= sw_rise;
    fall_or |= sw_fall;
    if (|(sw_rise | sw_fall)) pulses++;
  endtask
  task automatic run(input int k);
    repeat (k) step();
  endtask
  task automatic clr();
    rise_or = '0;
    fall_or = '0;
    pulses = 0;
  endtask
  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h03};
    vecs[1] = '{8'hA5, 8'hA5, 8'hA5, 8'h00};
    vecs[2] = '{8'h5A, 8'h5A, 8'h5A, 8'hA5};
    vecs[3] = '{8'hFF, 8'hFF, 8'hA5, 8'h00};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_level", sw_level, 8'h00);
    chk("rst_rise", sw_rise, 8'h00);
    chk("rst_fall", sw_fall, 8'h00);
    chk("rst_evt_valid", evt_valid, 1'b0);
    clr();
    run(5);
    chk("rst_unqualified_level", sw_level, 8'h00);
    chk("rst_unqualified_pulses", pulses, 0);
    sw_in = 8'h00;
    run(20);
    chk("rst_settled_level", sw_level, 8'h00);
    clr();
    sw_in = 8'h01;
    n = 0;
    while (!sw_level[0] && n < 40) begin
      step();
      n++;
    end
    chk("edge_latency_11_14", n >= 11 && n <= 14, 1'b1);
    run(10);
    chk("edge_level", sw_level, 8'h01);
    chk("edge_rise", rise_or, 8'h01);
    chk("edge_fall", fall_or, 8'h00);
    chk("edge_pulse_cycles", pulses, 1);
    clr();
    for (int k = 0; k < 12; k++) begin
      sw_in[1] = ~k[0];
      run(5);
    end
    chk("bounce_no_pulse", pulses, 0);
    chk("bounce_level", sw_level, 8'h01);
    sw_in[1] = 1'b1;
    clr();
    run(20);
    chk("bounce_settle_level", sw_level, 8'h03);
    chk("bounce_settle_rise", rise_or, 8'h02);
    chk("bounce_settle_pulse_cycles", pulses, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr();
      sw_in = vecs[i].sw;
      run(20);
      chk($sformatf("vec%0d_level", i), sw_level, vecs[i].level);
      chk($sformatf("vec%0d_rise", i), rise_or, vecs[i].rise);
      chk($sformatf("vec%0d_fall", i), fall_or, vecs[i].fall);
      chk($sformatf("vec%0d_pulse_cycles", i), pulses, 1);
    end
`ifdef DEBOUNCE_EVENT_EN
    chk("evt_idle_after_accepts", evt_valid, 1'b0);
    evt_ready = 1'b0;
    sw_in = 8'h04;
    run(20);
    chk("evt_rise_valid", evt_valid, 1'b1);
    chk("evt_rise_mask", evt_mask, 8'h04);
    chk("evt_rise_level", evt_level, 8'h04);
    chk("evt_rise_ovf", evt_ovf, 1'b0);
    sw_in = 8'h00;
    run(20);
    chk("evt_fall_valid", evt_valid, 1'b1);
    chk("evt_fall_mask", evt_mask, 8'h04);
    chk("evt_fall_level", evt_level, 8'h00);
    chk("evt_fall_ovf", evt_ovf, 1'b1);
    sw_in = 8'h08;
    n = 0;
    while (!sw_rise[3] && n < 40) begin
      step();
      n++;
    end
    chk("evt_b3_rise_seen", sw_rise[3], 1'b1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("evt_fresh_valid", evt_valid, 1'b1);
    chk("evt_fresh_mask", evt_mask, 8'h08);
    chk("evt_fresh_ovf", evt_ovf, 1'b0);
    chk("evt_fresh_level", evt_level, 8'h08);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("evt_accept_idle", evt_valid, 1'b0);
    chk("evt_accept_mask", evt_mask, 8'h00);
`else
    sw_in = 8'h08;
    run(20);
    chk("evt_off_valid", evt_valid, 1'b0);
    chk("evt_off_mask", evt_mask, 8'h00);
    chk("evt_off_level", evt_level, 8'h00);
    chk("evt_off_ovf", evt_ovf, 1'b0);
`endif
    chk("pre_mid_level", sw_level, 8'h08);
    sw_in = 8'hF0;
    run(10);
    chk("mid_unqualified_level", sw_level, 8'h08);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    chk("mid_rst_level", sw_level, 8'h00);
    chk("mid_rst_rise", sw_rise, 8'h00);
    chk("mid_rst_evt_valid", evt_valid, 1'b0);
    clr();
    n = 0;
    while (sw_level != 8'hF0 && n < 40) begin
      step();
      n++;
    end
    chk("mid_full_requalify_latency", n, 12);
    run(5);
    chk("mid_rise", rise_or, 8'hF0);
    chk("mid_fall", fall_or, 8'h00);
    chk("mid_pulse_cycles", pulses, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
